// File: rtl/vend_pkg.sv
// Shared types and coin constants for the guffin vending sequencer.
package vend_pkg;

  localparam int unsigned COIN_Q = 1;
  localparam int unsigned COIN_H = 2;
  localparam int unsigned COIN_D = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCUM  = 3'd1,
    ST_VEND   = 3'd2,
    ST_CHANGE = 3'd3,
    ST_REFUND = 3'd4
  } vend_state_t;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'b00,
    COIN_QUARTER = 2'b01,
    COIN_HALF    = 2'b10,
    COIN_DOLLAR  = 2'b11
  } coin_t;

  // Value of an encoded coin in quarters.
  function automatic logic [2:0] coin_value(input coin_t c);
    case (c)
      COIN_QUARTER: return 3'(COIN_Q);
      COIN_HALF:    return 3'(COIN_H);
      COIN_DOLLAR:  return 3'(COIN_D);
      default:      return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_unit.sv
// Remaining-change register; emits one half-dollar or quarter pulse per cycle, halves first.
module vend_change_unit
  import vend_pkg::*;
#(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         step,
  output logic         half,
  output logic         quarter,
  output logic [W-1:0] next_remaining_c,
  output logic         done_c
);

  logic [W-1:0] remaining;
  logic [W-1:0] dispensed;

  // Remaining value after the coin currently being pulsed.
  always_comb begin
    dispensed = '0;
    if (half) begin
      dispensed = W'(COIN_H);
    end else if (quarter) begin
      dispensed = W'(COIN_Q);
    end
    next_remaining_c = remaining - dispensed;
    done_c           = (next_remaining_c == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remaining <= '0;
      half      <= 1'b0;
      quarter   <= 1'b0;
    end else if (load) begin
      remaining <= load_value;
      half      <= (load_value >= W'(COIN_H));
      quarter   <= (load_value == W'(COIN_Q));
    end else if (step) begin
      remaining <= next_remaining_c;
      half      <= (next_remaining_c >= W'(COIN_H));
      quarter   <= (next_remaining_c == W'(COIN_Q));
    end else begin
      remaining <= '0;
      half      <= 1'b0;
      quarter   <= 1'b0;
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Guffin vending sequencer: credit accumulation, vend pulse and change dispensing.
// Defining VEND_REFUND_EN adds a cancel input and the REFUND state.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned PRICE_Q  = 4,
  parameter int unsigned CREDIT_W = 3
) (
  input  logic                CLK,
  input  logic                RES,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
`ifdef VEND_REFUND_EN
  input  logic                cancel,
`endif
  output logic                coin_ready,
  output logic                guffin,
  output logic                quarter_out,
  output logic                halfDollar_out,
  output logic [CREDIT_W-1:0] credit_q,
  output logic [2:0]          state_code,
  output logic                busy
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  vend_state_t         state;
  logic                cancel_c;
  logic                accept_c;
  logic                vend_hit_c;
  logic                refund_c;
  logic [SUM_W-1:0]    sum_c;
  logic [CREDIT_W-1:0] credit_new_c;
  logic [CREDIT_W-1:0] change_c;
  logic                load_c;
  logic                step_c;
  logic [CREDIT_W-1:0] load_value_c;
  logic [CREDIT_W-1:0] next_remaining_c;
  logic                done_c;

`ifdef VEND_REFUND_EN
  assign cancel_c = cancel;
`else
  assign cancel_c = 1'b0;
`endif

  // Coin acceptance, vend/refund decisions and change-unit control.
  always_comb begin
    accept_c     = coin_valid && coin_ready && (coin_type != 2'b00);
    sum_c        = SUM_W'(credit_q) + SUM_W'(coin_value(coin_t'(coin_type)));
    credit_new_c = accept_c ? CREDIT_W'(sum_c) : credit_q;
    vend_hit_c   = accept_c && (sum_c >= SUM_W'(PRICE_Q));
    refund_c     = cancel_c && (state == ST_ACCUM) && !vend_hit_c;
    change_c     = credit_q - CREDIT_W'(PRICE_Q);
    load_c       = 1'b0;
    step_c       = 1'b0;
    load_value_c = '0;
    case (state)
      ST_ACCUM: begin
        if (refund_c) begin
          load_c       = 1'b1;
          load_value_c = credit_new_c;
        end
      end
      ST_VEND: begin
        load_c       = 1'b1;
        load_value_c = change_c;
      end
      ST_CHANGE, ST_REFUND: step_c = !done_c;
      default: ;
    endcase
  end

  vend_change_unit #(
    .W (CREDIT_W)
  ) u_change (
    .clk              (CLK),
    .rst_n            (RES),
    .load             (load_c),
    .load_value       (load_value_c),
    .step             (step_c),
    .half             (halfDollar_out),
    .quarter          (quarter_out),
    .next_remaining_c (next_remaining_c),
    .done_c           (done_c)
  );

  always_ff @(posedge CLK) begin
    if (!RES) begin
      state      <= ST_IDLE;
      credit_q   <= '0;
      guffin     <= 1'b0;
      coin_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      guffin <= 1'b0;
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (vend_hit_c) begin
            state      <= ST_VEND;
            credit_q   <= credit_new_c;
            guffin     <= 1'b1;
            coin_ready <= 1'b0;
            busy       <= 1'b1;
          end else if (refund_c) begin
            state      <= ST_REFUND;
            credit_q   <= credit_new_c;
            coin_ready <= 1'b0;
            busy       <= 1'b1;
          end else if (accept_c) begin
            state    <= ST_ACCUM;
            credit_q <= credit_new_c;
          end
        end
        ST_VEND: begin
          credit_q <= change_c;
          if (change_c == '0) begin
            state      <= ST_IDLE;
            coin_ready <= 1'b1;
            busy       <= 1'b0;
          end else begin
            state <= ST_CHANGE;
          end
        end
        ST_CHANGE, ST_REFUND: begin
          if (done_c) begin
            state      <= ST_IDLE;
            credit_q   <= '0;
            coin_ready <= 1'b1;
            busy       <= 1'b0;
          end else begin
            credit_q <= next_remaining_c;
          end
        end
        default: begin
          state      <= ST_IDLE;
          credit_q   <= '0;
          coin_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  assign state_code = 3'(state);

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed scoreboard bench for vend_sequencer (PRICE_Q=4, CREDIT_W=3).
module tb_vend_sequencer;

  typedef struct packed {
    logic       rdy;
    logic       gf;
    logic       qo;
    logic       ho;
    logic [2:0] cr;
    logic [2:0] sc;
    logic       bz;
  } snap_t;

  logic       CLK;
  logic       RES;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       cancel;
  logic       coin_ready;
  logic       guffin;
  logic       quarter_out;
  logic       halfDollar_out;
  logic [2:0] credit_q;
  logic [2:0] state_code;
  logic       busy;

  int    checks;
  int    errors;
  int    step_no;
  snap_t sb[$];

  vend_sequencer #(
    .PRICE_Q  (4),
    .CREDIT_W (3)
  ) dut (
    .CLK            (CLK),
    .RES            (RES),
    .coin_valid     (coin_valid),
    .coin_type      (coin_type),
`ifdef VEND_REFUND_EN
    .cancel         (cancel),
`endif
    .coin_ready     (coin_ready),
    .guffin         (guffin),
    .quarter_out    (quarter_out),
    .halfDollar_out (halfDollar_out),
    .credit_q       (credit_q),
    .state_code     (state_code),
    .busy           (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s step %0d observed %0h expected %0h", tag, step_no, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, push the expected post-edge outputs, then pop and compare.
  task automatic cyc(input logic v, input logic [1:0] t, input logic c, input logic rs,
                     input logic rdy, input logic gf, input logic qo, input logic ho,
                     input logic [2:0] cr, input logic [2:0] sc, input logic bz);
    snap_t e;
    coin_valid = v;
    coin_type  = t;
    cancel     = c;
    RES        = rs;
    sb.push_back('{rdy: rdy, gf: gf, qo: qo, ho: ho, cr: cr, sc: sc, bz: bz});
    @(posedge CLK);
    #1;
    step_no++;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty step %0d", step_no);
    end else begin
      e = sb.pop_front();
      check("coin_ready", 8'(coin_ready), 8'(e.rdy));
      check("guffin", 8'(guffin), 8'(e.gf));
      check("quarter_out", 8'(quarter_out), 8'(e.qo));
      check("halfDollar_out", 8'(halfDollar_out), 8'(e.ho));
      check("credit_q", 8'(credit_q), 8'(e.cr));
      check("state_code", 8'(state_code), 8'(e.sc));
      check("busy", 8'(busy), 8'(e.bz));
      check("pulse_exclusive", 8'(quarter_out && halfDollar_out), 8'd0);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    step_no    = 0;
    coin_valid = 1'b0;
    coin_type  = 2'b00;
    cancel     = 1'b0;
    RES        = 1'b0;

    // Reset held two cycles with coin strobes present
    //  v  t      c  rs   rdy g  q  h  cr sc bz
    cyc(1, 2'b11, 0, 0,   1,  0, 0, 0, 0, 0, 0);
    cyc(1, 2'b01, 0, 0,   1,  0, 0, 0, 0, 0, 0);
    cyc(0, 2'b00, 0, 1,   1,  0, 0, 0, 0, 0, 0);
    // Strobe with type 00 is ignored
    cyc(1, 2'b00, 0, 1,   1,  0, 0, 0, 0, 0, 0);

    // Exact price: four quarters
    cyc(1, 2'b01, 0, 1,   1,  0, 0, 0, 1, 1, 0);
    cyc(1, 2'b01, 0, 1,   1,  0, 0, 0, 2, 1, 0);
    cyc(1, 2'b01, 0, 1,   1,  0, 0, 0, 3, 1, 0);
    cyc(1, 2'b01, 0, 1,   0,  1, 0, 0, 4, 2, 1);
    cyc(0, 2'b00, 0, 1,   1,  0, 0, 0, 0, 0, 0);

    // Overpay attempt: half, half, dollar rejected while in VEND
    cyc(1, 2'b10, 0, 1,   1,  0, 0, 0, 2, 1, 0);
    cyc(1, 2'b10, 0, 1,   0,  1, 0, 0, 4, 2, 1);
    cyc(1, 2'b11, 0, 1,   1,  0, 0, 0, 0, 0, 0);
    cyc(0, 2'b00, 0, 1,   1,  0, 0, 0, 0, 0, 0);

    // Change of 3: half then quarter
    cyc(1, 2'b01, 0, 1,   1,  0, 0, 0, 1, 1, 0);
    cyc(1, 2'b01, 0, 1,   1,  0, 0, 0, 2, 1, 0);
    cyc(1, 2'b01, 0, 1,   1,  0, 0, 0, 3, 1, 0);
    cyc(1, 2'b11, 0, 1,   0,  1, 0, 0, 7, 2, 1);
    cyc(0, 2'b00, 0, 1,   0,  0, 0, 1, 3, 3, 1);
    cyc(0, 2'b00, 0, 1,   0,  0, 1, 0, 1, 3, 1);
    cyc(0, 2'b00, 0, 1,   1,  0, 0, 0, 0, 0, 0);

    // Busy rejection: dollars every cycle; first accepted in first IDLE cycle
    cyc(1, 2'b01, 0, 1,   1,  0, 0, 0, 1, 1, 0);
    cyc(1, 2'b01, 0, 1,   1,  0, 0, 0, 2, 1, 0);
    cyc(1, 2'b01, 0, 1,   1,  0, 0, 0, 3, 1, 0);
    cyc(1, 2'b11, 0, 1,   0,  1, 0, 0, 7, 2, 1);
    cyc(1, 2'b11, 0, 1,   0,  0, 0, 1, 3, 3, 1);
    cyc(1, 2'b11, 0, 1,   0,  0, 1, 0, 1, 3, 1);
    cyc(1, 2'b11, 0, 1,   1,  0, 0, 0, 0, 0, 0);
    cyc(1, 2'b11, 0, 1,   0,  1, 0, 0, 4, 2, 1);
    cyc(0, 2'b00, 0, 1,   1,  0, 0, 0, 0, 0, 0);

    // Type 00 in ACCUM ignored; change of 1 is a single quarter
    cyc(1, 2'b01, 0, 1,   1,  0, 0, 0, 1, 1, 0);
    cyc(1, 2'b00, 0, 1,   1,  0, 0, 0, 1, 1, 0);
    cyc(1, 2'b10, 0, 1,   1,  0, 0, 0, 3, 1, 0);
    cyc(1, 2'b10, 0, 1,   0,  1, 0, 0, 5, 2, 1);
    cyc(0, 2'b00, 0, 1,   0,  0, 1, 0, 1, 3, 1);
    cyc(0, 2'b00, 0, 1,   1,  0, 0, 0, 0, 0, 0);

    // Change of 2 is a single half dollar
    cyc(1, 2'b01, 0, 1,   1,  0, 0, 0, 1, 1, 0);
    cyc(1, 2'b01, 0, 1,   1,  0, 0, 0, 2, 1, 0);
    cyc(1, 2'b11, 0, 1,   0,  1, 0, 0, 6, 2, 1);
    cyc(0, 2'b00, 0, 1,   0,  0, 0, 1, 2, 3, 1);
    cyc(0, 2'b00, 0, 1,   1,  0, 0, 0, 0, 0, 0);

    // Reset in the middle of CHANGE drops pending change
    cyc(1, 2'b01, 0, 1,   1,  0, 0, 0, 1, 1, 0);
    cyc(1, 2'b01, 0, 1,   1,  0, 0, 0, 2, 1, 0);
    cyc(1, 2'b01, 0, 1,   1,  0, 0, 0, 3, 1, 0);
    cyc(1, 2'b11, 0, 1,   0,  1, 0, 0, 7, 2, 1);
    cyc(0, 2'b00, 0, 1,   0,  0, 0, 1, 3, 3, 1);
    cyc(0, 2'b00, 0, 0,   1,  0, 0, 0, 0, 0, 0);
    cyc(0, 2'b00, 0, 1,   1,  0, 0, 0, 0, 0, 0);

`ifdef VEND_REFUND_EN
    // Cancel in IDLE ignored; half then cancel refunds one half dollar
    cyc(0, 2'b00, 1, 1,   1,  0, 0, 0, 0, 0, 0);
    cyc(1, 2'b10, 0, 1,   1,  0, 0, 0, 2, 1, 0);
    cyc(0, 2'b00, 1, 1,   0,  0, 0, 1, 2, 4, 1);
    cyc(0, 2'b00, 1, 1,   1,  0, 0, 0, 0, 0, 0);
    // Coin and cancel together below price: refund includes the coin
    cyc(1, 2'b01, 0, 1,   1,  0, 0, 0, 1, 1, 0);
    cyc(1, 2'b10, 1, 1,   0,  0, 0, 1, 3, 4, 1);
    cyc(0, 2'b00, 1, 1,   0,  0, 1, 0, 1, 4, 1);
    cyc(0, 2'b00, 0, 1,   1,  0, 0, 0, 0, 0, 0);
    // Coin and cancel together reaching price: vend wins
    cyc(1, 2'b01, 0, 1,   1,  0, 0, 0, 1, 1, 0);
    cyc(1, 2'b01, 0, 1,   1,  0, 0, 0, 2, 1, 0);
    cyc(1, 2'b01, 0, 1,   1,  0, 0, 0, 3, 1, 0);
    cyc(1, 2'b10, 1, 1,   0,  1, 0, 0, 5, 2, 1);
    cyc(0, 2'b00, 1, 1,   0,  0, 1, 0, 1, 3, 1);
    cyc(0, 2'b00, 0, 1,   1,  0, 0, 0, 0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
